// File: rtl/name_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// name_pattern_pkg
// Shared types and constants for the ASCII name pattern generator:
//   - gen_state_t : generator FSM states
//   - ASCII_SPACE : separator character used between repeated words
//   - DEFAULT_NAME / DEFAULT_NAME_LEN : default transmitted string
//   - name_char() : pick character idx out of a packed string (first char in MSBs)
// ---------------------------------------------------------------------------
package name_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_SEP  = 2'd3
  } gen_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int DEFAULT_NAME_LEN = 7;
  localparam logic [8*DEFAULT_NAME_LEN-1:0] DEFAULT_NAME = 56'h49_4D_54_49_59_41_5A;

  // Character index width: covers strings of up to 32 characters.
  localparam int IDX_W = 5;

  // The string is zero-extended to 256 bits by the caller so one function
  // serves every NAME_LEN; character idx sits at byte (last_idx - idx).
  function automatic logic [7:0] name_char(input logic [255:0] name_vec,
                                           input logic [4:0]   last_idx,
                                           input logic [4:0]   idx);
    logic [4:0] pos;
    logic [7:0] base;
    pos  = last_idx - idx;
    base = {pos, 3'b000};
    return name_vec[base +: 8];
  endfunction

endpackage

// File: rtl/name_gap_timer.sv
// ---------------------------------------------------------------------------
// name_gap_timer
// 8-bit load/decrement counter that times the idle gap between words.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (takes priority over i_en)
//   i_load_val     : value to load
//   i_en           : decrement by one, holding at zero
//   o_zero         : counter is zero
// ---------------------------------------------------------------------------
module name_gap_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [7:0] r_count;

  // Counter register: load wins, decrement saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/name_pattern_gen.sv
// ---------------------------------------------------------------------------
// name_pattern_gen
// Transmit side of the ASCII letter stream: sends NAME one character per
// valid/ready transfer, single-shot or repeating, with optional idle gap.
// Optional feature macro: NAME_GEN_SEP_EN -- when defined, a space (8'h20)
// is sent between repeated words (not counted as a word, skipped on stop).
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : asynchronous active-low reset
//   start      : request a word (ignored unless idle)
//   repeat_en  : sampled with start, 1 = repeat words until stop
//   stop       : end repeat at the next word boundary (or at once in a gap)
//   letter_o   : current character
//   valid_o    : letter_o is valid
//   ready_i    : sink accepts letter_o when valid_o && ready_i
//   busy       : generator active
//   done       : one-cycle pulse after the last character of a word transfers
//   word_cnt   : words completed since last start, saturating
// All outputs come straight from flops; the next values are computed from the
// next state so a start at cycle N shows character 0 at cycle N+1.
// ---------------------------------------------------------------------------
module name_pattern_gen
  import name_pattern_pkg::*;
#(
  parameter int                    NAME_LEN = DEFAULT_NAME_LEN,
  parameter logic [8*NAME_LEN-1:0] NAME     = DEFAULT_NAME,
  parameter int                    GAP      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        repeat_en,
  input  logic        stop,
  output logic [7:0]  letter_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NAME_LEN - 1);
  localparam bit               GAP_EN   = (GAP > 0);
  // The timer is checked for zero on each gap cycle, so GAP-1 gives GAP cycles.
  localparam logic [7:0]       GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  gen_state_t       r_state;
  gen_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_repeat;
  logic             r_stop;

  logic [7:0]       r_letter;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_word_cnt;

  logic [7:0]       w_letter_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [15:0]      w_word_cnt_nxt;

  logic             w_start_acc;
  logic             w_stop_seen;
  logic             w_last_xfer;
  logic             w_timer_load;
  logic             w_timer_en;
  logic             w_timer_zero;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  // A stop arriving in the same cycle as the word boundary still counts.
  assign w_stop_seen = r_stop || stop;

  name_gap_timer u_gap_timer (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_timer_load),
    .i_load_val (GAP_LOAD),
    .i_en       (w_timer_en),
    .o_zero     (w_timer_zero)
  );

  // FSM state register plus the repeat and stop latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_repeat <= 1'b0;
      r_stop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_start_acc) begin
        r_repeat <= repeat_en;
      end else begin
        r_repeat <= r_repeat;
      end
      // Stop is only remembered while active; idle clears it so a stop that
      // coincides with start is dropped.
      if (r_state == ST_IDLE) begin
        r_stop <= 1'b0;
      end else if (stop) begin
        r_stop <= 1'b1;
      end else begin
        r_stop <= r_stop;
      end
    end
  end

  // Next-state logic: character index, word boundary and gap timer control.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_last_xfer  = 1'b0;
    w_timer_load = 1'b0;
    w_timer_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (ready_i && (r_idx == LAST_IDX)) begin
          w_last_xfer = 1'b1;
          w_idx_nxt   = '0;
          if (!r_repeat || w_stop_seen) begin
            w_state_nxt = ST_IDLE;
          end else begin
`ifdef NAME_GEN_SEP_EN
            w_state_nxt = ST_SEP;
`else
            w_state_nxt  = GAP_EN ? ST_GAP : ST_SEND;
            w_timer_load = GAP_EN;
`endif
          end
        end else if (ready_i) begin
          w_idx_nxt = r_idx + 1'b1;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        w_idx_nxt = '0;
        if (w_stop_seen) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timer_zero) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      ST_SEP: begin
        w_idx_nxt = '0;
`ifdef NAME_GEN_SEP_EN
        if (ready_i && w_stop_seen) begin
          w_state_nxt = ST_IDLE;
        end else if (ready_i) begin
          w_state_nxt  = GAP_EN ? ST_GAP : ST_SEND;
          w_timer_load = GAP_EN;
        end else begin
          w_state_nxt = ST_SEP;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state, so registered outputs line up with it.
  always_comb begin
    w_valid_nxt    = 1'b0;
    w_letter_nxt   = 8'h00;
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_done_nxt     = w_last_xfer;
    w_word_cnt_nxt = r_word_cnt;
    case (w_state_nxt)
      ST_SEND: begin
        w_valid_nxt  = 1'b1;
        w_letter_nxt = name_char(256'(NAME), LAST_IDX, w_idx_nxt);
      end
      ST_SEP: begin
        w_valid_nxt  = 1'b1;
        w_letter_nxt = ASCII_SPACE;
      end
      default: begin
        w_valid_nxt  = 1'b0;
        w_letter_nxt = 8'h00;
      end
    endcase
    if (w_start_acc) begin
      w_word_cnt_nxt = 16'h0000;
    end else if (w_last_xfer && (r_word_cnt != 16'hFFFF)) begin
      w_word_cnt_nxt = r_word_cnt + 16'h0001;
    end else begin
      w_word_cnt_nxt = r_word_cnt;
    end
  end

  // Output registers: a stalled transfer keeps the same next state, so
  // letter_o and valid_o hold stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_letter   <= 8'h00;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_word_cnt <= 16'h0000;
    end else begin
      r_letter   <= w_letter_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  assign letter_o = r_letter;
  assign valid_o  = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign word_cnt = r_word_cnt;

endmodule
